cpu_run_controller: RTL and testbench



---
 rtl/cpu_run_controller.sv | 152 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer: fetches instruction bytes, hands them to the datapath and tracks pc/count.
// Optional macro STEP_MODE_EN enables single-instruction stepping via step_btn.
module cpu_run_controller #(
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        halt_btn,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  instr,
  output logic        instr_valid,
  input  logic        cpu_done,
  input  logic [7:0]  next_pc,
  output logic [7:0]  pc,
  output logic        running,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [3:0] TMO_LIMIT = 4'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  instr_q, instr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  tmo_q, tmo_d;
  logic        halt_pend_q, halt_pend_d;
  logic        ivld_q, ivld_d;
  logic        step_q, step_d;
  logic [3:0]  tmo_inc;

  assign tmo_inc = tmo_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    halt_pend_d = halt_pend_q;
    step_d      = step_q;
    ivld_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_btn) begin
          state_d = S_FETCH;
          tmo_d   = 4'd0;
          step_d  = 1'b0;
`ifdef STEP_MODE_EN
        end else if (step_btn) begin
          state_d = S_FETCH;
          tmo_d   = 4'd0;
          step_d  = 1'b1;
`endif
        end
      end
      S_FETCH: begin
        if (halt_btn) halt_pend_d = 1'b1;
        if (mem_ack) begin
          // A halt opcode never reaches the datapath and is not counted.
          if (mem_data == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            state_d = S_EXEC;
            instr_d = mem_data;
            ivld_d  = 1'b1;
          end
        end else if (tmo_inc == TMO_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_EXEC: begin
        if (halt_btn) halt_pend_d = 1'b1;
        if (cpu_done) begin
          pc_d = next_pc;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (step_q || halt_pend_q || halt_btn) begin
            state_d     = S_IDLE;
            halt_pend_d = 1'b0;
            step_d      = 1'b0;
          end else begin
            state_d = S_FETCH;
            tmo_d   = 4'd0;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= 8'h00;
      instr_q     <= 8'h00;
      cnt_q       <= 16'h0000;
      tmo_q       <= 4'd0;
      halt_pend_q <= 1'b0;
      ivld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      halt_pend_q <= halt_pend_d;
      ivld_q      <= ivld_d;
    end
  end

`ifdef STEP_MODE_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step_d;
  end
`else
  logic unused_step;
  assign step_q      = 1'b0;
  assign unused_step = step_btn ^ step_d;
`endif

  // Request decodes straight from state so an async reset drops it with no clock edge.
  assign mem_req     = (state_q == S_FETCH);
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = ivld_q;
  assign pc          = pc_q;
  assign running     = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: run/halt, timeout fault, halt button, pc wrap, async reset, stepping.
module tb_cpu_run_controller;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        run_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_btn = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        cpu_done = 1'b0;
  logic [7:0]  next_pc = 8'h00;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        running;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;
  int n;

  cpu_run_controller #(.HALT_OPCODE(8'hFF), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .reset(reset), .run_btn(run_btn), .step_btn(step_btn), .halt_btn(halt_btn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .cpu_done(cpu_done), .next_pc(next_pc),
    .pc(pc), .running(running), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic press_run;
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
  endtask

  // One instruction: ack one cycle after req, cpu_done one cycle after instr_valid.
  task automatic fetch_exec(input logic [7:0] exp_pc, input logic [7:0] data, input logic [7:0] npc,
                            input logic halt_in_fetch, input logic [15:0] exp_cnt);
    check("fe_req", 32'(mem_req), 1);
    check("fe_addr", 32'(mem_addr), 32'(exp_pc));
    cpu_done = 1'b1;
    next_pc  = 8'hAA;
    halt_btn = halt_in_fetch;
    tick();
    cpu_done = 1'b0;
    halt_btn = 1'b0;
    check("fe_hold_req", 32'(mem_req), 1);
    check("fe_hold_addr", 32'(mem_addr), 32'(exp_pc));
    check("fe_stray_done_pc", 32'(pc), 32'(exp_pc));
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    check("ex_valid", 32'(instr_valid), 1);
    check("ex_instr", 32'(instr), 32'(data));
    check("ex_req_low", 32'(mem_req), 0);
    check("ex_running", 32'(running), 1);
    mem_ack  = 1'b1;
    mem_data = 8'h77;
    tick();
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    check("ex_valid_pulse", 32'(instr_valid), 0);
    check("ex_stray_ack", 32'(instr), 32'(data));
    cpu_done = 1'b1;
    next_pc  = npc;
    tick();
    cpu_done = 1'b0;
    check("ex_pc", 32'(pc), 32'(npc));
    check("ex_count", 32'(instr_count), 32'(exp_cnt));
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_req", 32'(mem_req), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_count", 32'(instr_count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_running", 32'(running), 0);

    // Program 44,49,19,FF
    press_run();
    fetch_exec(8'h00, 8'h44, 8'h01, 1'b0, 16'd1);
    fetch_exec(8'h01, 8'h49, 8'h02, 1'b0, 16'd2);
    fetch_exec(8'h02, 8'h19, 8'h03, 1'b0, 16'd3);
    check("halt_fetch_addr", 32'(mem_addr), 3);
    tick();
    mem_ack  = 1'b1;
    mem_data = 8'hFF;
    tick();
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    check("halt_halted", 32'(halted), 1);
    check("halt_running", 32'(running), 0);
    check("halt_req", 32'(mem_req), 0);
    check("halt_instr", 32'(instr), 32'h19);
    check("halt_valid", 32'(instr_valid), 0);
    check("halt_count", 32'(instr_count), 3);
    check("halt_pc", 32'(pc), 3);
    press_run();
    tick();
    check("halt_sticky", 32'(halted), 1);
    check("halt_sticky_req", 32'(mem_req), 0);

    // Withheld ack
    do_reset();
    press_run();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      n++;
      tick();
    end
    check("tmo_cycles", 32'(n), 15);
    check("tmo_fault", 32'(fault), 1);
    check("tmo_req", 32'(mem_req), 0);
    check("tmo_running", 32'(running), 0);
    press_run();
    tick();
    check("fault_sticky", 32'(fault), 1);
    check("fault_sticky_req", 32'(mem_req), 0);

    // Halt button
    do_reset();
    halt_btn = 1'b1;
    tick();
    halt_btn = 1'b0;
    check("idle_halt_ignored", 32'(running), 0);
    press_run();
    fetch_exec(8'h00, 8'h11, 8'h05, 1'b0, 16'd1);
    fetch_exec(8'h05, 8'h22, 8'h06, 1'b1, 16'd2);
    check("hb_running", 32'(running), 0);
    check("hb_halted", 32'(halted), 0);
    check("hb_req", 32'(mem_req), 0);
    check("hb_pc", 32'(pc), 6);
    press_run();
    fetch_exec(8'h06, 8'h33, 8'h07, 1'b0, 16'd3);
    check("hb_resume_req", 32'(mem_req), 1);
    check("hb_resume_addr", 32'(mem_addr), 7);

    // pc wrap and async reset mid-EXEC
    fetch_exec(8'h07, 8'h55, 8'hFF, 1'b0, 16'd4);
    fetch_exec(8'hFF, 8'h66, 8'h00, 1'b0, 16'd5);
    check("wrap_req", 32'(mem_req), 1);
    check("wrap_addr", 32'(mem_addr), 0);
    tick();
    mem_ack  = 1'b1;
    mem_data = 8'h5A;
    tick();
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    check("mid_exec_valid", 32'(instr_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 0);
    check("arst_count", 32'(instr_count), 0);
    check("arst_req", 32'(mem_req), 0);
    check("arst_running", 32'(running), 0);
    check("arst_instr", 32'(instr), 0);
    check("arst_valid", 32'(instr_valid), 0);
    tick();
    reset = 1'b1;
    tick();

`ifdef STEP_MODE_EN
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    fetch_exec(8'h00, 8'h01, 8'h01, 1'b0, 16'd1);
    check("step1_running", 32'(running), 0);
    check("step1_req", 32'(mem_req), 0);
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    fetch_exec(8'h01, 8'h02, 8'h02, 1'b0, 16'd2);
    check("step2_running", 32'(running), 0);
    check("step2_pc", 32'(pc), 2);
    run_btn  = 1'b1;
    step_btn = 1'b1;
    tick();
    run_btn  = 1'b0;
    step_btn = 1'b0;
    fetch_exec(8'h02, 8'h03, 8'h03, 1'b0, 16'd3);
    check("run_wins_req", 32'(mem_req), 1);
`else
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    check("step_ignored_running", 32'(running), 0);
    check("step_ignored_req", 32'(mem_req), 0);
    check("step_ignored_count", 32'(instr_count), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
